// File: rtl/writeback_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NREQ result producers.
// Grant is combinational; the winner's write reaches res_* one cycle later.
module writeback_arbiter #(
    parameter int NREQ  = 3,
    parameter int CNT_W = 32,
    parameter int XLEN  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_v_i,
    input  logic [NREQ*5-1:0]    req_adr_i,
    input  logic [NREQ*XLEN-1:0] req_data_i,
    output logic [NREQ-1:0]      req_ok_o,
    output logic                 res_v,
    output logic [4:0]           res_adr,
    output logic [XLEN-1:0]      res_data,
    output logic [CNT_W-1:0]     contention_o
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NREQ - 1);

    logic [PTR_W-1:0] r_rr;
    logic [PTR_W-1:0] w_gidx;
    logic             w_found;
    logic [PTR_W-1:0] w_rr_nxt;
    logic [4:0]       w_adr;
    logic [XLEN-1:0]  w_data;
    logic             w_multi;
    int               w_idx;

    // Scan from the pointer upward with wrap; the first valid requester wins.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = int'(r_rr) + k;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (!w_found && req_v_i[w_idx]) begin
                w_found = 1'b1;
                w_gidx  = PTR_W'(w_idx);
            end
        end
    end

    always_comb begin
        req_ok_o = '0;
        if (w_found && rst_n) begin
            req_ok_o[w_gidx] = 1'b1;
        end
    end

    always_comb begin
        w_adr  = '0;
        w_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (PTR_W'(i) == w_gidx) begin
                w_adr  = req_adr_i[5*i +: 5];
                w_data = req_data_i[XLEN*i +: XLEN];
            end
        end
    end

    assign w_rr_nxt = (w_gidx == LAST_IDX) ? '0 : w_gidx + 1'b1;
    assign w_multi  = ($countones(req_v_i) >= 2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr <= '0;
        end else if (w_found) begin
            r_rr <= w_rr_nxt;
        end
    end

    // x0 writes are accepted and retired without raising the write enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_v    <= 1'b0;
            res_adr  <= '0;
            res_data <= '0;
        end else if (w_found) begin
            res_v    <= (w_adr != 5'd0);
            res_adr  <= w_adr;
            res_data <= w_data;
        end else begin
            res_v    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            contention_o <= '0;
        end else if (w_multi && (contention_o != {CNT_W{1'b1}})) begin
            contention_o <= contention_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: a per-cycle reference model plus literal spot checks.
module tb_writeback_arbiter;

    localparam int NREQ  = 3;
    localparam int CNT_W = 32;
    localparam int XLEN  = 32;

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      req_v_i;
    logic [NREQ*5-1:0]    req_adr_i;
    logic [NREQ*XLEN-1:0] req_data_i;
    logic [NREQ-1:0]      req_ok_o;
    logic                 res_v;
    logic [4:0]           res_adr;
    logic [XLEN-1:0]      res_data;
    logic [CNT_W-1:0]     contention_o;

    int n_vec  = 0;
    int n_miss = 0;

    writeback_arbiter #(.NREQ(NREQ), .CNT_W(CNT_W), .XLEN(XLEN)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_v_i      (req_v_i),
        .req_adr_i    (req_adr_i),
        .req_data_i   (req_data_i),
        .req_ok_o     (req_ok_o),
        .res_v        (res_v),
        .res_adr      (res_adr),
        .res_data     (res_data),
        .contention_o (contention_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pointer as a plain integer, results as the last accepted write.
    int              m_rr;
    logic            m_res_v;
    logic [4:0]      m_res_adr;
    logic [XLEN-1:0] m_res_data;
    longint          m_cnt;

    function automatic int winner(input int rr, input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rr = 0; m_res_v = 1'b0; m_res_adr = '0; m_res_data = '0; m_cnt = 0;
        end else begin
            int g;
            int pop;
            g = winner(m_rr, req_v_i);
            pop = 0;
            for (int i = 0; i < NREQ; i++) pop += int'(req_v_i[i]);
            if (g >= 0) begin
                m_res_adr  = req_adr_i[5*g +: 5];
                m_res_data = req_data_i[XLEN*g +: XLEN];
                m_res_v    = (m_res_adr != 0);
                m_rr       = (g + 1) % NREQ;
            end else begin
                m_res_v = 1'b0;
            end
            if (pop >= 2 && m_cnt < 64'hFFFF_FFFF) m_cnt++;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [NREQ-1:0] e_ok;
        int g;
        e_ok = '0;
        g = winner(m_rr, req_v_i);
        if (rst_n && g >= 0) e_ok[g] = 1'b1;
        chk("model ok", longint'(req_ok_o), longint'(e_ok));
        chk("model res_v", longint'(res_v), longint'(m_res_v));
        chk("model res_adr", longint'(res_adr), longint'(m_res_adr));
        chk("model res_data", longint'(res_data), longint'(m_res_data));
        chk("model contention", longint'(contention_o), m_cnt);
    end

    logic [4:0]      a_tab [NREQ];
    logic [XLEN-1:0] d_tab [NREQ];

    task automatic drive(input logic [NREQ-1:0] v);
        req_v_i = v;
        for (int i = 0; i < NREQ; i++) begin
            req_adr_i[5*i +: 5]        = a_tab[i];
            req_data_i[XLEN*i +: XLEN] = d_tab[i];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [2:0] rr_exp [6];

    initial begin
        rr_exp[0] = 3'b100; rr_exp[1] = 3'b001; rr_exp[2] = 3'b010;
        rr_exp[3] = 3'b100; rr_exp[4] = 3'b001; rr_exp[5] = 3'b010;
        for (int i = 0; i < NREQ; i++) begin
            a_tab[i] = 5'(i + 1);
            d_tab[i] = 32'h1000_0000 + 32'(i);
        end
        rst_n = 1'b0;
        drive(3'b111);

        // Reset with every unit requesting.
        repeat (2) @(negedge clk);
        chk("reset ok", longint'(req_ok_o), 0);
        chk("reset res_v", longint'(res_v), 0);
        chk("reset contention", longint'(contention_o), 0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("first grant", longint'(req_ok_o), 3'b001);
        tick();
        drive(3'b000);
        @(negedge clk);
        chk("first res_adr", longint'(res_adr), 1);
        chk("first contention", longint'(contention_o), 1);

        // Single requester.
        tick();
        a_tab[1] = 5'd5; d_tab[1] = 32'hDEADBEEF;
        drive(3'b010);
        @(negedge clk);
        chk("single ok", longint'(req_ok_o), 3'b010);
        tick();
        drive(3'b000);
        @(negedge clk);
        chk("single res_v", longint'(res_v), 1);
        chk("single res_adr", longint'(res_adr), 5);
        chk("single res_data", longint'(res_data), 32'hDEADBEEF);

        // All three valid: pointer sits at 2 after the single transfer.
        for (int k = 0; k < 6; k++) begin
            tick();
            for (int i = 0; i < NREQ; i++) d_tab[i] = 32'(k * 16 + i);
            drive(3'b111);
            @(negedge clk);
            chk("rr ok", longint'(req_ok_o), longint'(rr_exp[k]));
        end
        tick();
        drive(3'b000);
        @(negedge clk);
        chk("rr contention", longint'(contention_o), 7);

        // x0 write by unit 2, then confirm the pointer wrapped to 0.
        tick();
        a_tab[2] = 5'd0;
        drive(3'b100);
        @(negedge clk);
        chk("x0 ok", longint'(req_ok_o), 3'b100);
        tick();
        drive(3'b000);
        @(negedge clk);
        chk("x0 res_v", longint'(res_v), 0);
        tick();
        a_tab[2] = 5'd7;
        drive(3'b111);
        @(negedge clk);
        chk("post x0 ok", longint'(req_ok_o), 3'b001);

        // Back-to-back from unit 0.
        for (int k = 0; k < 4; k++) begin
            tick();
            d_tab[0] = 32'hA000_0000 + 32'(k);
            drive(3'b001);
            @(negedge clk);
            chk("b2b ok", longint'(req_ok_o), 3'b001);
            if (k > 0) begin
                chk("b2b res_v", longint'(res_v), 1);
                chk("b2b res_data", longint'(res_data), 32'hA000_0000 + 32'(k - 1));
            end
        end
        tick();
        drive(3'b000);
        @(negedge clk);
        chk("b2b last res_v", longint'(res_v), 1);
        chk("b2b last res_data", longint'(res_data), 32'hA000_0003);
        chk("b2b contention", longint'(contention_o), 8);

        // Asynchronous reset between edges while a write is on the port.
        drive(3'b111);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async res_v", longint'(res_v), 0);
        chk("async contention", longint'(contention_o), 0);
        chk("async ok", longint'(req_ok_o), 0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post reset ok", longint'(req_ok_o), 3'b001);
        tick();
        drive(3'b000);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
